joypad_emulator: RTL and testbench

JOYPAD_EMULATOR -- requirements
Module: joypad_emulator

---
 rtl/vnes_pkg.sv | 18 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/joypad_emulator.sv | 57 +++++
 tb/tb_joypad_emulator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vnes_pkg.sv
// Shared constants for the NES controller path: button bit positions and
// the default debounce window, used by the joypad and controller port blocks.
package vnes_pkg;

    localparam int unsigned NUM_BTNS  = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam logic [15:0] DEBOUNCE_CYCLES_DEFAULT = 16'd50000;

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-flop synchronizer followed by a stable-count
// debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import vnes_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic        meta_q;
    logic        sync_q;
    logic        level_q;
    logic        level_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Any return to the accepted level restarts the count, rejecting glitches.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q + 16'd1;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/joypad_emulator.sv
// NES joypad emulator: debounces eight raw buttons and serves them through a
// 4021-style parallel-load / serial-shift register, active-low on the wire.
module joypad_emulator
    import vnes_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_in,
    input  logic                ctrlr_latch,
    input  logic                ctrlr_clk,
    output logic                ctrlr_out,
    output logic [NUM_BTNS-1:0] btn_state
);

    logic [NUM_BTNS-1:0] btn_db;
    logic [7:0]          sh_q;
    logic [7:0]          sh_d;
    logic                clk_prev_q;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (btn_in[i]),
            .level_o(btn_db[i])
        );
    end

    // Latch is level-sensitive and wins over a coincident shift-clock edge;
    // ones fill in from the top so an over-read reports "not pressed".
    always_comb begin
        sh_d = sh_q;
        if (ctrlr_latch) begin
            sh_d = ~btn_db;
        end else if (ctrlr_clk && !clk_prev_q) begin
            sh_d = {1'b1, sh_q[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q       <= '1;
            clk_prev_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            clk_prev_q <= ctrlr_clk;
        end
    end

    assign ctrlr_out = sh_q[BTN_A];
    assign btn_state = btn_db;

endmodule

// File: tb/tb_joypad_emulator.sv
// Directed self-checking bench for joypad_emulator with a 4-cycle debounce.
module tb_joypad_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] btn_in = 8'h00;
    logic       ctrlr_latch = 1'b0;
    logic       ctrlr_clk = 1'b0;
    logic       ctrlr_out;
    logic [7:0] btn_state;

    int tests = 0;
    int fails = 0;

    joypad_emulator #(
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .ctrlr_latch(ctrlr_latch),
        .ctrlr_clk  (ctrlr_clk),
        .ctrlr_out  (ctrlr_out),
        .btn_state  (btn_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic shift_one();
        ctrlr_clk = 1'b1;
        step(1);
        ctrlr_clk = 1'b0;
        step(1);
    endtask

    // Latch then seven rising shift clocks; bit i of v is the i-th serial bit.
    task automatic read_byte(output logic [7:0] v);
        ctrlr_latch = 1'b1;
        step(1);
        ctrlr_latch = 1'b0;
        v[0] = ctrlr_out;
        for (int i = 1; i < 8; i++) begin
            ctrlr_clk = 1'b1;
            step(1);
            v[i] = ctrlr_out;
            ctrlr_clk = 1'b0;
            step(1);
        end
    endtask

    logic [7:0] rd;
    logic [7:0] extra;
    logic       glitch_seen;

    initial begin
        // Reset state
        step(2);
        check("reset_out", {7'd0, ctrlr_out}, 8'h01);
        check("reset_state", btn_state, 8'h00);
        reset = 1'b0;
        step(1);

        // Debounce latency: 2 sync + 4 stable cycles
        btn_in = 8'h09;
        step(5);
        check("deb_early", btn_state, 8'h00);
        step(1);
        check("deb_accept", btn_state, 8'h09);
        step(4);
        read_byte(rd);
        check("read_09", rd, 8'hF6);
        for (int i = 0; i < 3; i++) begin
            ctrlr_clk = 1'b1;
            step(1);
            extra[i] = ctrlr_out;
            ctrlr_clk = 1'b0;
            step(1);
        end
        check("overread_09", {5'd0, extra[2:0]}, 8'h07);

        // Glitch rejection: 3-cycle pulse on B
        btn_in = 8'h00;
        step(10);
        check("release_09", btn_state, 8'h00);
        btn_in = 8'h02;
        step(3);
        btn_in = 8'h00;
        glitch_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (btn_state != 8'h00) glitch_seen = 1'b1;
        end
        check("glitch_state", {7'd0, glitch_seen}, 8'h00);
        read_byte(rd);
        check("glitch_read", rd, 8'hFF);

        // Latch priority over coincident shift clock
        btn_in = 8'h01;
        step(10);
        check("state_01", btn_state, 8'h01);
        ctrlr_latch = 1'b1;
        ctrlr_clk = 1'b1;
        glitch_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (ctrlr_out !== 1'b0) glitch_seen = 1'b1;
        end
        check("latch_prio", {7'd0, glitch_seen}, 8'h00);
        ctrlr_latch = 1'b0;
        step(3);
        check("clk_held_high", {7'd0, ctrlr_out}, 8'h00);
        ctrlr_clk = 1'b0;
        step(1);
        check("clk_fall_noshift", {7'd0, ctrlr_out}, 8'h00);
        ctrlr_clk = 1'b1;
        step(1);
        check("fresh_rise", {7'd0, ctrlr_out}, 8'h01);
        ctrlr_clk = 1'b0;
        step(1);

        // Debounced change mid-sequence does not disturb the shift
        btn_in = 8'h00;
        step(10);
        check("state_00", btn_state, 8'h00);
        ctrlr_latch = 1'b1;
        step(1);
        ctrlr_latch = 1'b0;
        for (int i = 0; i < 3; i++) shift_one();
        btn_in = 8'hFF;
        step(10);
        check("state_FF", btn_state, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            ctrlr_clk = 1'b1;
            step(1);
            extra[i] = ctrlr_out;
            ctrlr_clk = 1'b0;
            step(1);
        end
        check("midshift_hold", {3'd0, extra[4:0]}, 8'h1F);
        read_byte(rd);
        check("read_FF", rd, 8'h00);

        // Reset mid-shift
        btn_in = 8'hAA;
        step(10);
        check("state_AA", btn_state, 8'hAA);
        ctrlr_latch = 1'b1;
        step(1);
        ctrlr_latch = 1'b0;
        check("AA_bit0", {7'd0, ctrlr_out}, 8'h01);
        for (int i = 0; i < 3; i++) shift_one();
        check("AA_bit3", {7'd0, ctrlr_out}, 8'h00);
        shift_one();
        check("AA_bit4", {7'd0, ctrlr_out}, 8'h01);
        reset = 1'b1;
        step(1);
        check("rst_mid_out", {7'd0, ctrlr_out}, 8'h01);
        check("rst_mid_state", btn_state, 8'h00);
        reset = 1'b0;
        shift_one();
        check("rst_shift_out", {7'd0, ctrlr_out}, 8'h01);
        read_byte(rd);
        check("rst_read", rd, 8'hFF);
        step(10);
        check("rst_redeb", btn_state, 8'hAA);
        read_byte(rd);
        check("read_AA", rd, 8'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
